// File: rtl/axi_lite_intr_slave_if.sv
// AXI4-Lite channel bundle for the interrupt-controller register window.
interface axi_lite_intr_slave_if #(
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32
);
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic [2:0]                      S_AXI_AWPROT;
   logic                            S_AXI_AWVALID;
   logic                            S_AXI_AWREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                            S_AXI_WVALID;
   logic                            S_AXI_WREADY;
   logic [1:0]                      S_AXI_BRESP;
   logic                            S_AXI_BVALID;
   logic                            S_AXI_BREADY;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [2:0]                      S_AXI_ARPROT;
   logic                            S_AXI_ARVALID;
   logic                            S_AXI_ARREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]                      S_AXI_RRESP;
   logic                            S_AXI_RVALID;
   logic                            S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/axi_lite_intr_slave.sv
// AXI4-Lite interrupt controller: sticky ISR capture, GIE/IER/IAR/IPR registers, registered irq.
// Optional macro INTR_SOFT_TRIGGER_EN turns word 0x14 into a write-only software trigger (ISTR).
module axi_lite_intr_slave #(
   parameter int unsigned C_NUM_OF_INTR      = 1,
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
   parameter int unsigned C_IRQ_SENSITIVITY  = 1,
   parameter int unsigned C_IRQ_ACTIVE_STATE = 1
) (
   input  logic                     ACLK,
   input  logic                     ARESETN,
   axi_lite_intr_slave_if.slave     S_AXI_INTR,
   input  logic [C_NUM_OF_INTR-1:0] irq_src,
   output logic                     irq
);
   localparam int unsigned N  = C_NUM_OF_INTR;
   localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
   localparam logic        IRQ_ACT  = 1'(C_IRQ_ACTIVE_STATE);
   localparam logic [2:0]  IDX_GIE  = 3'd0;
   localparam logic [2:0]  IDX_IER  = 3'd1;
   localparam logic [2:0]  IDX_ISR  = 3'd2;
   localparam logic [2:0]  IDX_IAR  = 3'd3;
   localparam logic [2:0]  IDX_IPR  = 3'd4;
   localparam logic [2:0]  IDX_ISTR = 3'd5;

   logic          r_awready, r_bvalid, r_arready, r_rvalid;
   logic [DW-1:0] r_rdata;
   logic          r_gie;
   logic [N-1:0]  r_ier, r_isr, r_src_d;
   logic          r_irq;

   logic          w_wr_fire, w_wr_hs, w_rd_hs;
   logic [2:0]    w_wr_idx, w_rd_idx;
   logic [DW-1:0] w_wmask, w_wbits, w_rd_mux;
   logic [N-1:0]  w_hit, w_ack, w_soft;
   logic          w_irq_cond;

   assign w_wr_fire = S_AXI_INTR.S_AXI_AWVALID & S_AXI_INTR.S_AXI_WVALID & ~r_bvalid & ~r_awready;
   assign w_wr_hs   = r_awready & S_AXI_INTR.S_AXI_AWVALID & S_AXI_INTR.S_AXI_WVALID;
   assign w_rd_hs   = r_arready & S_AXI_INTR.S_AXI_ARVALID;
   assign w_wr_idx  = S_AXI_INTR.S_AXI_AWADDR[4:2];
   assign w_rd_idx  = S_AXI_INTR.S_AXI_ARADDR[4:2];

   // Byte-strobe expansion so GIE/IER/IAR/ISTR only see enabled lanes
   always_comb begin
      w_wmask = '0;
      for (int b = 0; b < DW/8; b++) begin
         w_wmask[b*8 +: 8] = {8{S_AXI_INTR.S_AXI_WSTRB[b]}};
      end
   end
   assign w_wbits = S_AXI_INTR.S_AXI_WDATA & w_wmask;

   assign w_ack = (w_wr_hs && w_wr_idx == IDX_IAR) ? w_wbits[N-1:0] : '0;
`ifdef INTR_SOFT_TRIGGER_EN
   assign w_soft = (w_wr_hs && w_wr_idx == IDX_ISTR) ? w_wbits[N-1:0] : '0;
`else
   assign w_soft = '0;
`endif

   assign w_hit      = (C_IRQ_SENSITIVITY != 0) ? (irq_src & ~r_src_d) : irq_src;
   assign w_irq_cond = r_gie & (|(r_isr & r_ier));

   always_comb begin
      w_rd_mux = '0;
      case (w_rd_idx)
         IDX_GIE: w_rd_mux = DW'(r_gie);
         IDX_IER: w_rd_mux = DW'(r_ier);
         IDX_ISR: w_rd_mux = DW'(r_isr);
         IDX_IPR: w_rd_mux = DW'(r_isr & r_ier);
         default: w_rd_mux = '0;
      endcase
   end

   // Write channel and control registers
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         r_awready <= 1'b0;
         r_bvalid  <= 1'b0;
         r_gie     <= 1'b0;
         r_ier     <= '0;
      end else begin
         r_awready <= w_wr_fire;
         if (w_wr_hs)
            r_bvalid <= 1'b1;
         else if (S_AXI_INTR.S_AXI_BREADY)
            r_bvalid <= 1'b0;
         if (w_wr_hs && w_wr_idx == IDX_GIE && S_AXI_INTR.S_AXI_WSTRB[0])
            r_gie <= S_AXI_INTR.S_AXI_WDATA[0];
         if (w_wr_hs && w_wr_idx == IDX_IER)
            r_ier <= (r_ier & ~w_wmask[N-1:0]) | w_wbits[N-1:0];
      end
   end

   // Capture: a new hit beats a same-cycle acknowledge
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         r_isr   <= '0;
         r_src_d <= '0;
         r_irq   <= ~IRQ_ACT;
      end else begin
         r_isr   <= w_hit | w_soft | (r_isr & ~w_ack);
         r_src_d <= irq_src;
         r_irq   <= w_irq_cond ? IRQ_ACT : ~IRQ_ACT;
      end
   end

   // Read channel: data is snapshotted at the address handshake and held until RREADY
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_arready <= S_AXI_INTR.S_AXI_ARVALID & ~r_rvalid & ~r_arready;
         if (w_rd_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_mux;
         end else if (S_AXI_INTR.S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   assign S_AXI_INTR.S_AXI_AWREADY = r_awready;
   assign S_AXI_INTR.S_AXI_WREADY  = r_awready;
   assign S_AXI_INTR.S_AXI_BVALID  = r_bvalid;
   assign S_AXI_INTR.S_AXI_BRESP   = 2'b00;
   assign S_AXI_INTR.S_AXI_ARREADY = r_arready;
   assign S_AXI_INTR.S_AXI_RVALID  = r_rvalid;
   assign S_AXI_INTR.S_AXI_RDATA   = r_rdata;
   assign S_AXI_INTR.S_AXI_RRESP   = 2'b00;
   assign irq                      = r_irq;
endmodule

// File: tb/tb_axi_lite_intr_slave.sv
// Directed bench for axi_lite_intr_slave (one source, edge capture, active-high irq).
module tb_axi_lite_intr_slave;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [0:0] irq_src;
   logic       irq;
   int         total = 0;
   int         bad   = 0;
   logic [31:0] rd;

   axi_lite_intr_slave_if #(.C_S_AXI_ADDR_WIDTH(5), .C_S_AXI_DATA_WIDTH(32)) bus ();

   axi_lite_intr_slave #(
      .C_NUM_OF_INTR(1), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5),
      .C_IRQ_SENSITIVITY(1), .C_IRQ_ACTIVE_STATE(1)
   ) dut (
      .ACLK(clk), .ARESETN(rst_n), .S_AXI_INTR(bus), .irq_src(irq_src), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit src_on_hs);
      int n = 0;
      bus.S_AXI_AWADDR  = a;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA   = d;
      bus.S_AXI_WSTRB   = s;
      bus.S_AXI_WVALID  = 1'b1;
      bus.S_AXI_BREADY  = 1'b1;
      while (!bus.S_AXI_AWREADY && n < 20) begin
         tick();
         n++;
      end
      chk("awready", 32'(bus.S_AXI_AWREADY & bus.S_AXI_WREADY), 32'd1);
      if (src_on_hs) irq_src[0] = 1'b1;
      tick();
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      chk("bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
      chk("bresp", 32'(bus.S_AXI_BRESP), 32'd0);
      tick();
      bus.S_AXI_BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
      int n = 0;
      bus.S_AXI_ARADDR  = a;
      bus.S_AXI_ARVALID = 1'b1;
      bus.S_AXI_RREADY  = 1'b0;
      while (!bus.S_AXI_ARREADY && n < 20) begin
         tick();
         n++;
      end
      chk("arready", 32'(bus.S_AXI_ARREADY), 32'd1);
      tick();
      bus.S_AXI_ARVALID = 1'b0;
      chk("rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
      chk("rresp", 32'(bus.S_AXI_RRESP), 32'd0);
      d = bus.S_AXI_RDATA;
      bus.S_AXI_RREADY = 1'b1;
      tick();
      bus.S_AXI_RREADY = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
      logic [31:0] d;
      axi_read(a, d);
      chk(tag, d, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      irq_src = '0;
      bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY = 1'b0;
      repeat (3) tick();

      // Reset state
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
      chk("rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
      chk("rst_rvalid", 32'(bus.S_AXI_RVALID), 32'd0);
      chk("rst_rdata", bus.S_AXI_RDATA, 32'd0);
      rst_n = 1'b1;
      tick();
      rd_chk("rd_gie0", 5'h00, 32'h0);
      rd_chk("rd_ier0", 5'h04, 32'h0);
      rd_chk("rd_isr0", 5'h08, 32'h0);
      rd_chk("rd_iar0", 5'h0C, 32'h0);
      rd_chk("rd_ipr0", 5'h10, 32'h0);
      chk("irq_idle", 32'(irq), 32'd0);

      // Enable and fire source 0
      axi_write(5'h00, 32'h1, 4'hF, 1'b0);
      axi_write(5'h04, 32'h1, 4'hF, 1'b0);
      rd_chk("rd_gie1", 5'h00, 32'h1);
      rd_chk("rd_ier1", 5'h04, 32'h1);
      irq_src[0] = 1'b1;
      tick();
      irq_src[0] = 1'b0;
      chk("irq_lat1", 32'(irq), 32'd0);
      tick();
      chk("irq_set", 32'(irq), 32'd1);
      rd_chk("rd_ipr1", 5'h10, 32'h1);
      rd_chk("rd_isr1", 5'h08, 32'h1);

      // Acknowledge clears
      axi_write(5'h0C, 32'h1, 4'hF, 1'b0);
      chk("irq_ack", 32'(irq), 32'd0);
      rd_chk("rd_ipr_ack", 5'h10, 32'h0);

      // Acknowledge coincident with a new rising edge: set wins
      axi_write(5'h0C, 32'h1, 4'hF, 1'b1);
      chk("irq_set_wins", 32'(irq), 32'd1);
      rd_chk("rd_isr_setwins", 5'h08, 32'h1);

      // Source held high: no new edge, so acknowledge sticks
      axi_write(5'h0C, 32'h1, 4'hF, 1'b0);
      rd_chk("rd_isr_held", 5'h08, 32'h0);
      chk("irq_held", 32'(irq), 32'd0);
      irq_src[0] = 1'b0;
      tick();

      // AW leads W by 3 cycles; BREADY low for 4 response cycles
      bus.S_AXI_AWADDR  = 5'h04;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA   = 32'hFFFF_FFFF;
      bus.S_AXI_WSTRB   = 4'hF;
      bus.S_AXI_BREADY  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("aw_wait", 32'(bus.S_AXI_AWREADY), 32'd0);
      end
      bus.S_AXI_WVALID = 1'b1;
      tick();
      chk("aw_accept", 32'(bus.S_AXI_AWREADY & bus.S_AXI_WREADY), 32'd1);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("b_hold", 32'(bus.S_AXI_BVALID), 32'd1);
         chk("no_second_aw", 32'(bus.S_AXI_AWREADY), 32'd0);
         if (i < 3) tick();
      end
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_BREADY  = 1'b1;
      tick();
      bus.S_AXI_BREADY  = 1'b0;
      chk("b_release", 32'(bus.S_AXI_BVALID), 32'd0);
      rd_chk("rd_ier_width", 5'h04, 32'h1);

      // Strobes, write-only and unmapped words
      axi_write(5'h00, 32'h0, 4'h0, 1'b0);
      rd_chk("rd_gie_nostrb", 5'h00, 32'h1);
      axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF, 1'b0);
      rd_chk("rd_unmapped18", 5'h18, 32'h0);
      rd_chk("rd_unmapped1c", 5'h1C, 32'h0);
      rd_chk("rd_isr_unmap", 5'h08, 32'h0);

      // Reset while a read response is pending
      irq_src[0] = 1'b1;
      tick();
      irq_src[0] = 1'b0;
      tick();
      chk("irq_pre_rst", 32'(irq), 32'd1);
      bus.S_AXI_ARADDR  = 5'h08;
      bus.S_AXI_ARVALID = 1'b1;
      for (int n = 0; n < 20 && !bus.S_AXI_ARREADY; n++) tick();
      chk("rst_ar", 32'(bus.S_AXI_ARREADY), 32'd1);
      tick();
      bus.S_AXI_ARVALID = 1'b0;
      chk("rst_rv_pend", 32'(bus.S_AXI_RVALID), 32'd1);
      rst_n = 1'b0;
      tick();
      chk("rst_rv_drop", 32'(bus.S_AXI_RVALID), 32'd0);
      chk("rst_irq_drop", 32'(irq), 32'd0);
      rst_n = 1'b1;
      tick();
      rd_chk("rd_gie_rst", 5'h00, 32'h0);
      rd_chk("rd_ier_rst", 5'h04, 32'h0);
      rd_chk("rd_isr_rst", 5'h08, 32'h0);

      // Software trigger word
      axi_write(5'h00, 32'h1, 4'hF, 1'b0);
      axi_write(5'h04, 32'h1, 4'hF, 1'b0);
      axi_write(5'h14, 32'h1, 4'hF, 1'b0);
`ifdef INTR_SOFT_TRIGGER_EN
      chk("istr_irq", 32'(irq), 32'd1);
      rd_chk("istr_isr", 5'h08, 32'h1);
`else
      chk("istr_irq", 32'(irq), 32'd0);
      rd_chk("istr_isr", 5'h08, 32'h0);
`endif
      rd_chk("istr_rd", 5'h14, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
